// File: rtl/x4_seq_approx_mul_pkg.sv
// Shared types and constants for the sequential approximate multiplier.
package x4_seq_approx_mul_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/x4_seq_approx_mul_if.sv
// Operand/result handshake bundle for the sequential approximate multiplier.
interface x4_seq_approx_mul_if #(
  parameter int unsigned N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/x4_seq_approx_mul_x2.sv
// 2x2 approximate multiplier: exact except 3x3, which yields 7.
module x2_approx_mul (
  input  logic [1:0] i_x,
  input  logic [1:0] i_y,
  output logic [3:0] o_p_c
);
  assign o_p_c = (i_x == 2'b11 && i_y == 2'b11) ? 4'd7
                                                : ({2'b00, i_x} * {2'b00, i_y});
endmodule

// File: rtl/x4_seq_approx_mul.sv
// Sequential approximate multiplier: one digit-pair product per cycle,
// shifted into a 2N-bit accumulator by a single shared 2x2 unit.
module x4_seq_approx_mul
  import x4_seq_approx_mul_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  x4_seq_approx_mul_if.slave  bus
);

  localparam int unsigned HALF = N / DIGIT_W;
  localparam int unsigned D    = HALF * HALF;
  localparam int unsigned IW   = $clog2(HALF);
  localparam int unsigned KW   = $clog2(D);
  localparam int unsigned SW   = IW + 2;
  localparam int unsigned PW   = 2 * N;

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic [KW-1:0]   r_k;
  logic [PW-1:0]   r_acc;
  logic            r_out_valid;
  logic            r_in_ready;

  logic            w_load;
  logic            w_step;
  logic            w_last;
  logic [1:0]      w_da;
  logic [1:0]      w_db;
  logic [3:0]      w_p;
  logic [IW:0]     w_isum;
  logic [SW-1:0]   w_sh;
  logic [PW-1:0]   w_pp;

  // Select the current digit pair and weight its product.
  assign w_da   = 2'(r_a >> {r_i, 1'b0});
  assign w_db   = 2'(r_b >> {r_j, 1'b0});
  assign w_isum = (IW+1)'(r_i) + (IW+1)'(r_j);
  assign w_sh   = {w_isum, 1'b0};
  assign w_pp   = PW'(w_p) << w_sh;
  assign w_last = (r_k == KW'(D - 1));

  x2_approx_mul u_x2 (
    .i_x   (w_da),
    .i_y   (w_db),
    .o_p_c (w_p)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_load = 1'b1;
          w_next = ST_CALC;
        end
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (r_out_valid && bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand latch, digit counters and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_acc <= '0;
    end else if (w_load) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_acc <= '0;
    end else if (w_step) begin
      r_acc <= r_acc + w_pp;
      r_k   <= r_k + KW'(1);
      if (r_i == IW'(HALF - 1)) begin
        r_i <= '0;
        r_j <= r_j + IW'(1);
      end else begin
        r_i <= r_i + IW'(1);
      end
    end
  end

  // Registered handshake outputs; out_valid trails DONE entry by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= (r_state == ST_DONE) && (w_next == ST_DONE);
      r_in_ready  <= (w_next == ST_IDLE);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_acc;

endmodule

// File: tb/tb_x4_seq_approx_mul.sv
// Self-checking bench for x4_seq_approx_mul (N=8).
module tb_x4_seq_approx_mul;

  localparam int unsigned N   = 8;
  localparam int          LAT = 17;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  x4_seq_approx_mul_if #(.N(N)) bus ();

  x4_seq_approx_mul #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product minus the error of each 3x3 digit pair (9 -> 7).
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int unsigned p;
    int unsigned dx;
    int unsigned dy;
    p = 32'(x) * 32'(y);
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        dx = (32'(x) >> (2 * i)) % 4;
        dy = (32'(y) >> (2 * j)) % 4;
        if (dx == 3 && dy == 3) p = p - 2 * (32'd1 << (2 * (i + j)));
      end
    end
    return 16'(p);
  endfunction

  // Present a pair, take it on the next edge, then count edges to out_valid.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input string name);
    int lat;
    logic [15:0] exp_v;
    exp_v = ref_mul(x, y);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready_before got=%b want=1", name, bus.in_ready);
    end
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s in_ready_calc got=%b want=0", name, bus.in_ready);
    end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, lat, LAT);
    end
    checks++;
    if (bus.out !== exp_v) begin
      failures++;
      $display("FAIL %s out a=%h b=%h got=%h want=%h", name, x, y, bus.out, exp_v);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_handshake out_valid=%b in_ready=%b want 0/1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 16'h0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state out_valid=%b out=%h in_ready=%b want 0/0000/1",
               bus.out_valid, bus.out, bus.in_ready);
    end
    rst_n = 1'b1;
    // First edge with rst_n high must already accept.
    run_op(8'h12, 8'h34, "first_accept");
  endtask

  task automatic test_directed();
    run_op(8'hFF, 8'hFF, "ff_ff");
    run_op(8'h03, 8'h03, "03_03");
    run_op(8'h00, 8'hA5, "zero_a");
    run_op(8'hA5, 8'h00, "zero_b");
    run_op(8'hAA, 8'h55, "aa_55");
    run_op(8'h0F, 8'hF0, "0f_f0");
    run_op(8'hC3, 8'h3C, "c3_3c");
  endtask

  task automatic test_stall();
    int lat;
    logic [15:0] exp_v;
    exp_v = ref_mul(8'hB7, 8'hE9);
    bus.a = 8'hB7;
    bus.b = 8'hE9;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL stall latency got=%0d want=%0d", lat, LAT);
    end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== exp_v || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d out_valid=%b out=%h in_ready=%b want 1/%h/0",
                 c, bus.out_valid, bus.out, bus.in_ready, exp_v);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release out_valid=%b in_ready=%b want 0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 16'h0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_state out_valid=%b out=%h in_ready=%b want 0/0000/1",
               bus.out_valid, bus.out, bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_discard valid_cycles=%0d in_ready=%b want 0/1",
               seen, bus.in_ready);
    end
    run_op(8'h02, 8'h03, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] x;
    logic [7:0] y;
    int lat;
    logic [15:0] exp_v;
    x = 8'($urandom);
    y = 8'($urandom);
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_v = ref_mul(x, y);
      @(posedge clk); #1;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 60) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat != LAT || bus.out !== exp_v) begin
        failures++;
        $display("FAIL b2b op=%0d lat=%0d out=%h want lat=%0d out=%h",
                 n, lat, bus.out, LAT, exp_v);
      end
      x = 8'($urandom);
      y = 8'($urandom);
      bus.a = x;
      bus.b = y;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_gap op=%0d out_valid=%b in_ready=%b want 0/1",
                 n, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    // Drain the final acceptance made at the loop exit edge, if any.
    @(posedge clk); #1;
    while (bus.in_ready !== 1'b1 && checks < 1000000) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      run_op(8'($urandom), 8'($urandom), "random");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
